// File: rtl/barrel_shift_sweep_ctrl.sv
// barrel_shift_sweep_ctrl
//   Sequencer placed directly upstream of barrel_shifter_top. On an accepted
//   start it latches one data word and steps the shifter's select input
//   through 0..STEPS-1. The shifter result for each step is registered and
//   emitted as one beat on a valid/ready stream, tagged with its shift amount.
//   A one-cycle done pulse follows acceptance of the final beat.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous, active-high reset
//   start      begin a sweep (only looked at while idle)
//   din        word to sweep, latched on the accepted start
//   busy       high whenever a sweep is in progress
//   sh_din     latched word, drives barrel_shifter_top.DIN
//   sh_sel     step counter, drives barrel_shifter_top.SEL
//   sh_dout    combinational result from barrel_shifter_top.DOUT
//   out_valid  dout/out_sel hold a result beat
//   out_ready  consumer accepts the beat when out_valid & out_ready at an edge
//   dout       captured shifter result
//   out_sel    shift amount that produced dout
//   done       one-cycle pulse after the final beat is accepted
module barrel_shift_sweep_ctrl #(
  parameter int WIDTH = 8,
  parameter int SELW  = 3,
  parameter int STEPS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic [WIDTH-1:0] sh_din,
  output logic [SELW-1:0]  sh_sel,
  input  logic [WIDTH-1:0] sh_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic [SELW-1:0]  out_sel,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    FINISH
  } state_e;

  // Terminal step; the counter stops here instead of wrapping, so STEPS may
  // equal 2**SELW without the compare aliasing back to zero.
  localparam logic [SELW-1:0] LAST_SEL = SELW'(STEPS - 1);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] sh_din_nxt;
  logic [SELW-1:0]  sh_sel_nxt;
  logic [WIDTH-1:0] dout_nxt;
  logic [SELW-1:0]  out_sel_nxt;
  logic             out_valid_nxt;
  logic             done_nxt;
  logic             slot_free;

  // State and datapath registers. Reset clears everything at once so an
  // aborted sweep leaves no partial beat behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sh_din    <= '0;
      sh_sel    <= '0;
      dout      <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      sh_din    <= sh_din_nxt;
      sh_sel    <= sh_sel_nxt;
      dout      <= dout_nxt;
      out_sel   <= out_sel_nxt;
      out_valid <= out_valid_nxt;
      done      <= done_nxt;
    end
  end

  // Next-state and next-register logic. The output slot is free when it is
  // empty or its beat is being taken this edge; while stalled the step
  // counter holds, so sh_dout stays stable for the pending capture.
  always_comb begin
    state_nxt     = state;
    sh_din_nxt    = sh_din;
    sh_sel_nxt    = sh_sel;
    dout_nxt      = dout;
    out_sel_nxt   = out_sel;
    out_valid_nxt = out_valid;
    done_nxt      = 1'b0;
    slot_free     = !out_valid || out_ready;

    case (state)
      IDLE: begin
        if (start) begin
          sh_din_nxt = din;
          sh_sel_nxt = '0;
          state_nxt  = SWEEP;
        end
      end
      SWEEP: begin
        if (slot_free) begin
          dout_nxt      = sh_dout;
          out_sel_nxt   = sh_sel;
          out_valid_nxt = 1'b1;
          if (sh_sel == LAST_SEL) begin
            state_nxt = FINISH;
          end else begin
            sh_sel_nxt = sh_sel + SELW'(1);
          end
        end
      end
      FINISH: begin
        // The final beat is always valid here; wait for it to be taken.
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          done_nxt      = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_barrel_shift_sweep_ctrl.sv
// tb_barrel_shift_sweep_ctrl
//   Self-checking bench for barrel_shift_sweep_ctrl. Two instances share the
//   same stimulus: dutA with STEPS=8 and dutB with STEPS=1; useOne selects
//   which one the model and checks look at. A left-rotate stands in for
//   barrel_shifter_top on each instance's sh_din/sh_sel.
module tb_barrel_shift_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] din;
  logic       outReady;

  logic       busyA, outValidA, doneA;
  logic [7:0] shDinA, shDoutA, doutA;
  logic [2:0] shSelA, outSelA;
  logic       busyB, outValidB, doneB;
  logic [7:0] shDinB, shDoutB, doutB;
  logic [2:0] shSelB, outSelB;

  logic       useOne;
  logic       busy, outValid, done;
  logic [7:0] shDin, dout;
  logic [2:0] shSel, outSel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Shifter stand-in: rotate left by k.
  function automatic logic [7:0] rotl(input logic [7:0] x, input logic [2:0] k);
    logic [15:0] w;
    w = {x, x} << k;
    return w[15:8];
  endfunction

  assign shDoutA = rotl(shDinA, shSelA);
  assign shDoutB = rotl(shDinB, shSelB);

  barrel_shift_sweep_ctrl #(.WIDTH(8), .SELW(3), .STEPS(8)) dutA (
    .clk(clk), .rst(rst), .start(start), .din(din), .busy(busyA),
    .sh_din(shDinA), .sh_sel(shSelA), .sh_dout(shDoutA),
    .out_valid(outValidA), .out_ready(outReady), .dout(doutA),
    .out_sel(outSelA), .done(doneA)
  );

  barrel_shift_sweep_ctrl #(.WIDTH(8), .SELW(3), .STEPS(1)) dutB (
    .clk(clk), .rst(rst), .start(start), .din(din), .busy(busyB),
    .sh_din(shDinB), .sh_sel(shSelB), .sh_dout(shDoutB),
    .out_valid(outValidB), .out_ready(outReady), .dout(doutB),
    .out_sel(outSelB), .done(doneB)
  );

  assign busy     = useOne ? busyB     : busyA;
  assign outValid = useOne ? outValidB : outValidA;
  assign done     = useOne ? doneB     : doneA;
  assign shDin    = useOne ? shDinB    : shDinA;
  assign dout     = useOne ? doutB     : doutA;
  assign shSel    = useOne ? shSelB    : shSelA;
  assign outSel   = useOne ? outSelB   : outSelA;

  // Reference model: a sweep is just the list of expected beats, popped in
  // order as the consumer takes them; the sweep ends when the list empties.
  typedef struct {
    logic [7:0] dout;
    logic [2:0] sel;
  } beat_t;

  beat_t      beatQ[$];
  bit         modelBusy;
  logic [7:0] modelWord;
  int         steps;
  int         tickCount;
  int         beatCount;
  int         doneCount;
  int         doneTicks[$];
  logic [7:0] seen [8];

  typedef struct {
    logic [7:0] din;
    logic [2:0] sel;
    logic [7:0] expDout;
    int         expTicks;
  } vec_t;

  vec_t vec [8];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [7:0] d, input logic r);
    start    = s;
    din      = d;
    outReady = r;
  endtask

  // One clock: note what the DUT is offering, step the edge, update the
  // model and compare. Called at posedge+1, returns at the next posedge+1.
  task automatic tick();
    bit         acc, stall, startTaken, doneExp;
    logic [7:0] prevDout, startWord;
    logic [2:0] prevSel;
    beat_t      b;
    acc        = (outValid === 1'b1) && (outReady === 1'b1);
    stall      = (outValid === 1'b1) && (outReady === 1'b0);
    prevDout   = dout;
    prevSel    = outSel;
    startTaken = (start === 1'b1) && !modelBusy;
    startWord  = din;
    @(posedge clk);
    #1;
    tickCount++;
    doneExp = 1'b0;
    if (acc) begin
      beatCount++;
      seen[prevSel] = prevDout;
      if (beatQ.size() == 0) begin
        checkOutput("extraBeat", 32'd1, 32'd0);
      end else begin
        b = beatQ.pop_front();
        checkOutput("beatDout", 32'(prevDout), 32'(b.dout));
        checkOutput("beatSel", 32'(prevSel), 32'(b.sel));
        if (beatQ.size() == 0) begin
          modelBusy = 1'b0;
          doneExp   = 1'b1;
        end
      end
    end
    if (startTaken) begin
      modelBusy = 1'b1;
      modelWord = startWord;
      beatCount = 0;
      for (int k = 0; k < steps; k++) begin
        b.dout = rotl(startWord, 3'(k));
        b.sel  = 3'(k);
        beatQ.push_back(b);
      end
    end
    checkOutput("busy", 32'(busy), 32'(modelBusy));
    checkOutput("done", 32'(done), 32'(doneExp));
    if (done === 1'b1) begin
      doneCount++;
      doneTicks.push_back(tickCount);
    end
    if (stall) begin
      checkOutput("stallValid", 32'(outValid), 32'd1);
      checkOutput("stallDout", 32'(dout), 32'(prevDout));
      checkOutput("stallSel", 32'(outSel), 32'(prevSel));
    end
    if (!modelBusy) begin
      checkOutput("idleValid", 32'(outValid), 32'd0);
    end else begin
      checkOutput("shDin", 32'(shDin), 32'(modelWord));
    end
  endtask

  task automatic waitDone(input int budget, input bit randomReady, output int taken);
    taken = 0;
    while (modelBusy && taken < budget) begin
      if (randomReady) outReady = ($urandom_range(0, 3) != 0);
      tick();
      taken++;
    end
    if (modelBusy) checkOutput("sweepTimeout", 32'd0, 32'd1);
  endtask

  task automatic runSweep(input logic [7:0] word, input bit randomReady, output int taken);
    foreach (seen[i]) seen[i] = 'x;
    applyStimulus(1'b1, word, 1'b1);
    tick();
    start = 1'b0;
    waitDone(80, randomReady, taken);
  endtask

  // Reset lands between edges; outputs must clear before the next edge.
  task automatic asyncReset(input bit checkZero);
    start = 1'b0;
    #2 rst = 1'b1;
    #1;
    if (checkZero) begin
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstValid", 32'(outValid), 32'd0);
      checkOutput("rstDone", 32'(done), 32'd0);
      checkOutput("rstDout", 32'(dout), 32'd0);
      checkOutput("rstShSel", 32'(shSel), 32'd0);
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    modelBusy = 1'b0;
    beatQ.delete();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int taken;
    int n;

    vec[0] = '{8'h0B, 3'd0, 8'h0B, 9};
    vec[1] = '{8'h0B, 3'd3, 8'h58, 9};
    vec[2] = '{8'h0B, 3'd7, 8'h85, 9};
    vec[3] = '{8'h51, 3'd2, 8'h45, 9};
    vec[4] = '{8'h51, 3'd4, 8'h15, 9};
    vec[5] = '{8'h80, 3'd1, 8'h01, 9};
    vec[6] = '{8'h01, 3'd7, 8'h80, 9};
    vec[7] = '{8'hFF, 3'd5, 8'hFF, 9};

    useOne    = 1'b0;
    steps     = 8;
    modelBusy = 1'b0;
    tickCount = 0;
    beatCount = 0;
    doneCount = 0;
    rst       = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1);
    #1;
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetValid", 32'(outValid), 32'd0);
    checkOutput("resetDone", 32'(done), 32'd0);
    checkOutput("resetDout", 32'(dout), 32'd0);
    checkOutput("resetShSel", 32'(shSel), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] table sweeps at full throughput");
    for (int i = 0; i < 8; i++) begin
      runSweep(vec[i].din, 1'b0, taken);
      checkOutput("tblDout", 32'(seen[vec[i].sel]), 32'(vec[i].expDout));
      checkOutput("tblTicks", 32'(taken), 32'(vec[i].expTicks));
      checkOutput("tblBeats", 32'(beatCount), 32'd8);
    end
    tick();

    $display("[TB] three-cycle stall at out_sel 2");
    applyStimulus(1'b1, 8'h51, 1'b1);
    tick();
    start = 1'b0;
    n = 0;
    while (!(outValid === 1'b1 && outSel == 3'd2) && n < 20) begin
      tick();
      n++;
    end
    checkOutput("reachSel2", 32'(outSel), 32'd2);
    outReady = 1'b0;
    repeat (3) tick();
    outReady = 1'b1;
    waitDone(40, 1'b0, taken);
    checkOutput("stallBeats", 32'(beatCount), 32'd8);

    $display("[TB] start ignored mid-sweep");
    applyStimulus(1'b1, 8'h0B, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h0B, 1'b1);
    repeat (3) tick();
    applyStimulus(1'b1, 8'hFF, 1'b1);
    tick();
    applyStimulus(1'b0, 8'hFF, 1'b1);
    waitDone(40, 1'b0, taken);
    checkOutput("ignoreBeats", 32'(beatCount), 32'd8);

    $display("[TB] reset mid-sweep then restart");
    applyStimulus(1'b1, 8'h0B, 1'b1);
    tick();
    start = 1'b0;
    n = 0;
    while (beatCount < 3 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("threeBeats", 32'(beatCount), 32'd3);
    asyncReset(1'b1);
    repeat (3) tick();
    runSweep(8'h51, 1'b0, taken);
    checkOutput("restartBeats", 32'(beatCount), 32'd8);
    checkOutput("restartSel0", 32'(seen[0]), 32'h51);

    $display("[TB] back-to-back single-step sweeps");
    asyncReset(1'b0);
    useOne = 1'b1;
    steps  = 1;
    doneCount = 0;
    doneTicks.delete();
    tickCount = 0;
    applyStimulus(1'b1, 8'hA7, 1'b1);
    repeat (12) tick();
    applyStimulus(1'b0, 8'hA7, 1'b1);
    waitDone(10, 1'b0, taken);
    checkOutput("b2bDones", 32'(doneCount), 32'd4);
    for (int i = 1; i < doneTicks.size(); i++) begin
      checkOutput("b2bGap", 32'(doneTicks[i] - doneTicks[i-1]), 32'd3);
    end

    $display("[TB] randomized traffic");
    asyncReset(1'b0);
    useOne    = 1'b0;
    steps     = 8;
    doneCount = 0;
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 3) != 0);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    waitDone(40, 1'b0, taken);
    checkOutput("randSweepsSeen", 32'(doneCount > 10), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
